// File: rtl/hex_digit_ctrl.sv
// Pushbutton front end for the VGA hex-digit painter: synchronizes and debounces
// inc/dec/clr buttons and drives a registered wrap-around hex digit with auto-repeat.
module hex_digit_ctrl #(
  parameter int unsigned DEB_CYCLES   = 1000000,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
  parameter logic [3:0]  RESET_VAL    = 4'h0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_clr,
  output logic [3:0] num,
  output logic       step
);

  localparam int INC = 0;
  localparam int DEC = 1;
  localparam int CLR = 2;

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1, sync2;
  logic [2:0]    lvl, prev;
  logic [DW-1:0] deb_cnt [3];

  state_t        state, state_n;
  logic [3:0]    num_n;
  logic          step_n;
  logic          dir, dir_n;
  logic [RW-1:0] rcnt, rcnt_n, rcnt_thr;

  logic          inc_rise, dec_rise, clr_rise;
  logic          held, both;
  logic [3:0]    stepped;

  assign btn_raw = {btn_clr, btn_dec, btn_inc};

  // Two-flop synchronizer, then a per-button debouncer that flips its level only
  // after DEB_CYCLES consecutive cycles of disagreement.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the small counter array is reset element by element.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      prev  <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          lvl[i]     <= ~lvl[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign inc_rise = lvl[INC] & ~prev[INC];
  assign dec_rise = lvl[DEC] & ~prev[DEC];
  assign clr_rise = lvl[CLR] & ~prev[CLR];
  assign both     = lvl[INC] & lvl[DEC];
  assign held     = dir ? lvl[INC] : lvl[DEC];
  assign stepped  = dir ? (num + 4'd1) : (num - 4'd1);
  assign rcnt_thr = (state == DELAY) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    num_n   = num;
    step_n  = 1'b0;
    dir_n   = dir;
    rcnt_n  = rcnt;

    if (clr_rise) begin
      num_n   = RESET_VAL;
      step_n  = 1'b1;
      state_n = IDLE;
      rcnt_n  = '0;
    end else if (lvl[CLR]) begin
      state_n = IDLE;
      rcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inc_rise && !lvl[DEC]) begin
            num_n   = num + 4'd1;
            step_n  = 1'b1;
            dir_n   = 1'b1;
            rcnt_n  = '0;
            state_n = DELAY;
          end else if (dec_rise && !lvl[INC]) begin
            num_n   = num - 4'd1;
            step_n  = 1'b1;
            dir_n   = 1'b0;
            rcnt_n  = '0;
            state_n = DELAY;
          end
        end
        DELAY, REPEAT: begin
          // Release of the selected button, or both held, abandons the repeat.
          if (both || !held) begin
            state_n = IDLE;
            rcnt_n  = '0;
          end else if (rcnt == rcnt_thr) begin
            num_n   = stepped;
            step_n  = 1'b1;
            rcnt_n  = '0;
            state_n = REPEAT;
          end else begin
            rcnt_n  = rcnt + RW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      num   <= RESET_VAL;
      step  <= 1'b0;
      dir   <= 1'b1;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      num   <= num_n;
      step  <= step_n;
      dir   <= dir_n;
      rcnt  <= rcnt_n;
    end
  end

endmodule

// File: tb/tb_hex_digit_ctrl.sv
// Bench for hex_digit_ctrl: table of button presses plus hold/repeat/reset sequences;
// expected step events (cycle, value) are queued at drive time and popped by a monitor.
module tb_hex_digit_ctrl;

  localparam int LAT = 7;  // 2 sync + 4 debounce + 1 edge detect

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] num;
  logic       step;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    logic [3:0] val;
  } step_t;

  typedef enum int {B_INC, B_DEC, B_CLR} btn_e;

  typedef struct {
    btn_e       btn;
    int         hold;
    int         gap;
    bit         steps;
    logic [3:0] exp_num;
  } vec_t;

  step_t exp_q[$];
  step_t mon_e;
  vec_t  vecs[13];

  hex_digit_ctrl #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (8),
    .RESET_VAL   (4'h0)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .btn_clr(btn_clr),
    .num    (num),
    .step   (step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_btn(input btn_e b, input logic v);
    case (b)
      B_INC:   btn_inc = v;
      B_DEC:   btn_dec = v;
      default: btn_clr = v;
    endcase
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_step(input int at, input logic [3:0] v);
    step_t e;
    e.at  = at;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic press(input btn_e b, input int hold, input int gap);
    set_btn(b, 1'b1);
    wait_cyc(hold);
    set_btn(b, 1'b0);
    wait_cyc(gap);
  endtask

  // Every observed step pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_step", {28'd0, num}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("step_cycle", cyc, mon_e.at);
        check("step_num", {28'd0, num}, {28'd0, mon_e.val});
      end
    end
  end

  initial begin
    int c;

    vecs[0]  = '{B_INC, 1, 3, 1'b0, 4'h0};
    vecs[1]  = '{B_INC, 2, 3, 1'b0, 4'h0};
    vecs[2]  = '{B_INC, 3, 3, 1'b0, 4'h0};
    vecs[3]  = '{B_INC, 1, 3, 1'b0, 4'h0};
    vecs[4]  = '{B_INC, 3, 12, 1'b0, 4'h0};
    vecs[5]  = '{B_INC, 10, 15, 1'b1, 4'h1};
    vecs[6]  = '{B_CLR, 10, 15, 1'b1, 4'h0};
    vecs[7]  = '{B_DEC, 10, 15, 1'b1, 4'hF};
    vecs[8]  = '{B_DEC, 10, 15, 1'b1, 4'hE};
    vecs[9]  = '{B_INC, 10, 15, 1'b1, 4'hF};
    vecs[10] = '{B_INC, 10, 15, 1'b1, 4'h0};
    vecs[11] = '{B_DEC, 10, 15, 1'b1, 4'hF};
    vecs[12] = '{B_CLR, 10, 15, 1'b1, 4'h0};

    wait_cyc(3);
    check("reset_num", {28'd0, num}, 32'h0);
    check("reset_step", {31'd0, step}, 32'h0);
    rstn = 1'b1;
    wait_cyc(5);

    foreach (vecs[i]) begin
      c = cyc;
      if (vecs[i].steps) push_step(c + LAT, vecs[i].exp_num);
      press(vecs[i].btn, vecs[i].hold, vecs[i].gap);
      check($sformatf("vec%0d_num", i), {28'd0, num}, {28'd0, vecs[i].exp_num});
      check($sformatf("vec%0d_pending", i), exp_q.size(), 32'd0);
    end

    // Auto-repeat on a held dec from 5: first step, +20, then every 8.
    for (int k = 1; k <= 5; k++) begin
      push_step(cyc + LAT, 4'(k));
      press(B_INC, 10, 15);
    end
    c = cyc;
    push_step(c + 7,  4'h4);
    push_step(c + 27, 4'h3);
    push_step(c + 35, 4'h2);
    push_step(c + 43, 4'h1);
    push_step(c + 51, 4'h0);
    push_step(c + 59, 4'hF);
    press(B_DEC, 60, 20);
    check("dec_hold_num", {28'd0, num}, 32'hF);
    check("dec_hold_pending", exp_q.size(), 32'd0);

    // inc in REPEAT, then dec also pressed: stepping stops, dec release is silent.
    c = cyc;
    push_step(c + 7,  4'h0);
    push_step(c + 27, 4'h1);
    push_step(c + 35, 4'h2);
    push_step(c + 43, 4'h3);
    btn_inc = 1'b1;
    wait_cyc(38);
    btn_dec = 1'b1;
    wait_cyc(22);
    btn_dec = 1'b0;
    wait_cyc(20);
    check("both_held_num", {28'd0, num}, 32'h3);
    check("both_held_pending", exp_q.size(), 32'd0);
    btn_inc = 1'b0;
    wait_cyc(15);

    // Asynchronous reset mid-repeat at num=9, inc still held through reset.
    for (int k = 4; k <= 7; k++) begin
      push_step(cyc + LAT, 4'(k));
      press(B_INC, 10, 15);
    end
    c = cyc;
    push_step(c + 7,  4'h8);
    push_step(c + 27, 4'h9);
    btn_inc = 1'b1;
    wait_cyc(30);
    check("pre_reset_num", {28'd0, num}, 32'h9);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_num", {28'd0, num}, 32'h0);
    check("async_reset_step", {31'd0, step}, 32'h0);
    wait_cyc(3);
    rstn = 1'b1;
    push_step(cyc + LAT, 4'h1);
    wait_cyc(10);
    btn_inc = 1'b0;
    wait_cyc(25);
    check("post_reset_num", {28'd0, num}, 32'h1);
    check("post_reset_pending", exp_q.size(), 32'd0);

    push_step(cyc + LAT, 4'h0);
    press(B_CLR, 10, 15);
    check("final_clr_num", {28'd0, num}, 32'h0);
    check("final_pending", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
